// File: rtl/block_writer.sv
// block_writer: queues {address, block} requests and serialises each block into
// 16-bit Avalon-MM write beats, low half first. Define BLOCK_WRITER_PERF_EN for perf counters.
module block_writer #(
   parameter  int NDWORDS = 9,
   parameter  int QDEPTH  = 2,
   localparam int BLOCKSZ = 32*NDWORDS
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [31:0]        baseaddr,
   input  logic [31:0]        index,
   input  logic [BLOCKSZ-1:0] data,
   input  logic               write,
   output logic               ready,
   output logic               done,
   output logic               busy,
   output logic               avm_m0_read,
   output logic               avm_m0_write,
   output logic [15:0]        avm_m0_writedata,
   output logic [31:0]        avm_m0_address,
   input  logic [15:0]        avm_m0_readdata,
   input  logic               avm_m0_readdatavalid,
   output logic [1:0]         avm_m0_byteenable,
   input  logic               avm_m0_waitrequest
`ifdef BLOCK_WRITER_PERF_EN
   ,
   output logic [31:0]        perf_nblocks,
   output logic [31:0]        perf_nstall
`endif
);

   localparam int NBEATS = 2*NDWORDS;
   localparam int BW     = $clog2(NBEATS);
   localparam int PW     = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
   localparam int CW     = $clog2(QDEPTH+1);

   typedef enum logic [1:0] {S_IDLE, S_BEAT, S_DONE} state_t;

   logic [31:0]        r_q_addr [QDEPTH];
   logic [BLOCKSZ-1:0] r_q_data [QDEPTH];
   logic [PW-1:0]      r_wptr, r_rptr;
   logic [CW-1:0]      r_count;

   state_t             r_state;
   logic [BW-1:0]      r_beat;
   logic               r_write;
   logic               r_done;
   logic [31:0]        r_addr;
   logic [BLOCKSZ-1:0] r_cur;

   logic               w_push, w_pop, w_beat_acc, w_last, w_load;
   logic [31:0]        w_acc_addr, w_ld_addr;
   logic [BLOCKSZ-1:0] w_ld_data;
   logic [PW-1:0]      w_rptr_nxt;
   logic               w_unused;

   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      if (p == PW'(QDEPTH-1)) return '0;
      return p + PW'(1);
   endfunction

   assign w_acc_addr  = baseaddr + index * 32'(4*NDWORDS);
   assign ready       = (r_count != CW'(QDEPTH));
   assign w_push      = write && ready;
   assign w_pop       = (r_state == S_DONE);
   assign w_beat_acc  = r_write && !avm_m0_waitrequest;
   assign w_last      = w_beat_acc && (r_beat == BW'(NBEATS-1));
   assign w_rptr_nxt  = ptr_inc(r_rptr);

   // Next block comes from the entry behind the head, or straight from the
   // input when that entry is being pushed in this very cycle.
   assign w_load = ((r_state == S_IDLE) && w_push) ||
                   ((r_state == S_DONE) && ((r_count > CW'(1)) || w_push));

   always_comb begin
      w_ld_addr = w_acc_addr;
      w_ld_data = data;
      if ((r_state == S_DONE) && (r_count > CW'(1))) begin
         w_ld_addr = r_q_addr[w_rptr_nxt];
         w_ld_data = r_q_data[w_rptr_nxt];
      end
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_q_addr[r_wptr] <= w_acc_addr;
         r_q_data[r_wptr] <= data;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (w_push) r_wptr <= ptr_inc(r_wptr);
         if (w_pop)  r_rptr <= w_rptr_nxt;
         if (w_push && !w_pop)      r_count <= r_count + CW'(1);
         else if (!w_push && w_pop) r_count <= r_count - CW'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state <= S_IDLE;
         r_beat  <= '0;
         r_write <= 1'b0;
         r_done  <= 1'b0;
         r_addr  <= '0;
         r_cur   <= '0;
      end else begin
         r_done <= 1'b0;
         if (w_load) begin
            r_state <= S_BEAT;
            r_write <= 1'b1;
            r_beat  <= '0;
            r_addr  <= w_ld_addr;
            r_cur   <= w_ld_data;
         end else if (r_state == S_DONE) begin
            r_state <= S_IDLE;
         end else if ((r_state == S_BEAT) && w_beat_acc) begin
            r_beat <= r_beat + BW'(1);
            r_addr <= r_addr + 32'd2;
            r_cur  <= r_cur >> 16;
            if (w_last) begin
               r_write <= 1'b0;
               r_done  <= 1'b1;
               r_state <= S_DONE;
            end
         end
      end
   end

`ifdef BLOCK_WRITER_PERF_EN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         perf_nblocks <= '0;
         perf_nstall  <= '0;
      end else begin
         if (r_done) perf_nblocks <= perf_nblocks + 32'd1;
         if (r_write && avm_m0_waitrequest) perf_nstall <= perf_nstall + 32'd1;
      end
   end
`endif

   assign done              = r_done;
   assign busy              = (r_count != '0) || (r_state != S_IDLE);
   assign avm_m0_read       = 1'b0;
   assign avm_m0_write      = r_write;
   assign avm_m0_writedata  = r_cur[15:0];
   assign avm_m0_address    = r_addr;
   assign avm_m0_byteenable = 2'b11;
   assign w_unused          = ^{avm_m0_readdata, avm_m0_readdatavalid};

endmodule

// File: tb/tb_block_writer.sv
// Directed bench for block_writer: a beat-level reference queue checked every cycle,
// plus literal timing/address expectations per scenario.
module tb_block_writer;

   localparam int NDW = 9;
   localparam int NB  = 2*NDW;
   localparam int BSZ = 32*NDW;

   logic           clk = 1'b0;
   logic           reset = 1'b0;
   logic [31:0]    baseaddr = '0;
   logic [31:0]    index = '0;
   logic [BSZ-1:0] data = '0;
   logic           write = 1'b0;
   logic           ready, done, busy;
   logic           avm_m0_read, avm_m0_write;
   logic [15:0]    avm_m0_writedata;
   logic [31:0]    avm_m0_address;
   logic [15:0]    avm_m0_readdata = '0;
   logic           avm_m0_readdatavalid = 1'b0;
   logic [1:0]     avm_m0_byteenable;
   logic           avm_m0_waitrequest = 1'b0;
`ifdef BLOCK_WRITER_PERF_EN
   logic [31:0]    perf_nblocks, perf_nstall;
`endif

   block_writer #(.NDWORDS(NDW), .QDEPTH(2)) dut (
      .clk(clk), .reset(reset), .baseaddr(baseaddr), .index(index), .data(data),
      .write(write), .ready(ready), .done(done), .busy(busy),
      .avm_m0_read(avm_m0_read), .avm_m0_write(avm_m0_write),
      .avm_m0_writedata(avm_m0_writedata), .avm_m0_address(avm_m0_address),
      .avm_m0_readdata(avm_m0_readdata), .avm_m0_readdatavalid(avm_m0_readdatavalid),
      .avm_m0_byteenable(avm_m0_byteenable), .avm_m0_waitrequest(avm_m0_waitrequest)
`ifdef BLOCK_WRITER_PERF_EN
      , .perf_nblocks(perf_nblocks), .perf_nstall(perf_nstall)
`endif
   );

   always #5 clk = ~clk;

   typedef struct {logic [31:0] b; logic [31:0] i; logic [BSZ-1:0] d;} req_t;
   typedef struct {logic [31:0] a; logic [15:0] d;} beat_t;

   req_t  pend [$];
   beat_t exp_q [$];

   int n_checks = 0;
   int n_errors = 0;
   int st_at = -1, st_len = 0, rst_at = -1;

   logic        obs_wr    [100];
   logic [31:0] obs_addr  [100];
   logic [15:0] obs_data  [100];
   logic        obs_done  [100];
   logic        obs_busy  [100];
   logic        obs_ready [100];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   function automatic logic [BSZ-1:0] mkblk(input logic [15:0] s);
      logic [BSZ-1:0] r;
      r = '0;
      for (int k = 0; k < NB; k++) r[16*k +: 16] = s + 16'(k);
      return r;
   endfunction

   task automatic add_req(input logic [31:0] b, input logic [31:0] i, input logic [BSZ-1:0] d);
      req_t r;
      r.b = b; r.i = i; r.d = d;
      pend.push_back(r);
   endtask

   // Reference: block lands at base + 4*NDWORDS*index, beat k at +2k, data[16k+15:16k].
   task automatic model_add(input req_t r);
      beat_t bt;
      logic [31:0] a0;
      a0 = r.b + r.i * 32'(4*NDW);
      for (int k = 0; k < NB; k++) begin
         bt.a = a0 + 32'(2*k);
         bt.d = r.d[16*k +: 16];
         exp_q.push_back(bt);
      end
   endtask

   task automatic run(input int ncyc);
      for (int c = 0; c < ncyc; c++) begin
         @(posedge clk); #1;
         if (rst_at >= 0 && c == rst_at) begin
            reset = 1'b0;
            pend.delete();
            exp_q.delete();
         end
         if (rst_at >= 0 && c == rst_at + 2) reset = 1'b1;
         avm_m0_waitrequest = (c >= st_at) && (c < st_at + st_len);
         if (pend.size() > 0) begin
            write = 1'b1; baseaddr = pend[0].b; index = pend[0].i; data = pend[0].d;
         end else begin
            write = 1'b0;
         end
         @(negedge clk);
         obs_wr[c]    = avm_m0_write;
         obs_addr[c]  = avm_m0_address;
         obs_data[c]  = avm_m0_writedata;
         obs_done[c]  = done;
         obs_busy[c]  = busy;
         obs_ready[c] = ready;
         if (write && ready && reset) begin
            model_add(pend[0]);
            void'(pend.pop_front());
         end
      end
      @(posedge clk); #1;
      write = 1'b0;
      avm_m0_waitrequest = 1'b0;
   endtask

   // Per-cycle compare against the reference beat queue and bus rules.
   logic        prev_stall = 1'b0, prev_done = 1'b0;
   logic [31:0] prev_addr = '0;
   logic [15:0] prev_data = '0;
   int          beats_seen = 0;

   always @(negedge clk) begin
      if (reset) begin
         chk("byteenable", 32'(avm_m0_byteenable), 32'h3);
         chk("read_tied", 32'(avm_m0_read), 32'h0);
         if (prev_stall) begin
            chk("stall_hold_write", 32'(avm_m0_write), 32'h1);
            chk("stall_hold_addr", avm_m0_address, prev_addr);
            chk("stall_hold_data", 32'(avm_m0_writedata), 32'(prev_data));
         end
         if (avm_m0_write && !avm_m0_waitrequest) begin
            if (exp_q.size() == 0) begin
               chk("unexpected_beat", avm_m0_address, 32'hDEADBEEF);
            end else begin
               chk("beat_addr", avm_m0_address, exp_q[0].a);
               chk("beat_data", 32'(avm_m0_writedata), 32'(exp_q[0].d));
               void'(exp_q.pop_front());
               beats_seen++;
            end
         end
         if (done) begin
            chk("done_after_all_beats", 32'(beats_seen), 32'(NB));
            chk("done_single_cycle", 32'(prev_done), 32'h0);
            beats_seen = 0;
         end
         prev_stall = avm_m0_write && avm_m0_waitrequest;
         prev_addr  = avm_m0_address;
         prev_data  = avm_m0_writedata;
         prev_done  = done;
      end else begin
         prev_stall = 1'b0;
         prev_done  = 1'b0;
         beats_seen = 0;
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_write", 32'(avm_m0_write), 32'h0);
      chk("rst_wdata", 32'(avm_m0_writedata), 32'h0);
      chk("rst_addr", avm_m0_address, 32'h0);
      chk("rst_done", 32'(done), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_ready", 32'(ready), 32'h1);
      chk("rst_be", 32'(avm_m0_byteenable), 32'h3);
      chk("rst_read", 32'(avm_m0_read), 32'h0);
      @(posedge clk); #1;
      reset = 1'b1;

      // Single block
      add_req(32'h1000, 32'd3, mkblk(16'hA000));
      run(22);
      chk("t1_ready0", 32'(obs_ready[0]), 32'h1);
      chk("t1_wr0", 32'(obs_wr[0]), 32'h0);
      chk("t1_wr1", 32'(obs_wr[1]), 32'h1);
      chk("t1_addr1", obs_addr[1], 32'h106C);
      chk("t1_data1", 32'(obs_data[1]), 32'hA000);
      chk("t1_addr18", obs_addr[18], 32'h108E);
      chk("t1_data18", 32'(obs_data[18]), 32'hA011);
      chk("t1_busy1", 32'(obs_busy[1]), 32'h1);
      chk("t1_done18", 32'(obs_done[18]), 32'h0);
      chk("t1_done19", 32'(obs_done[19]), 32'h1);
      chk("t1_wr19", 32'(obs_wr[19]), 32'h0);
      chk("t1_busy19", 32'(obs_busy[19]), 32'h1);
      chk("t1_busy20", 32'(obs_busy[20]), 32'h0);
      chk("t1_done20", 32'(obs_done[20]), 32'h0);

      // Stall on beat 4 for 5 cycles
      st_at = 5; st_len = 5;
      add_req(32'h1000, 32'd3, mkblk(16'hB000));
      run(27);
      st_at = -1; st_len = 0;
      for (int c = 5; c <= 9; c++) begin
         chk("t2_hold_addr", obs_addr[c], 32'h1074);
         chk("t2_hold_data", 32'(obs_data[c]), 32'hB004);
      end
      chk("t2_addr10", obs_addr[10], 32'h1074);
      chk("t2_addr11", obs_addr[11], 32'h1076);
      chk("t2_done23", 32'(obs_done[23]), 32'h0);
      chk("t2_done24", 32'(obs_done[24]), 32'h1);
`ifdef BLOCK_WRITER_PERF_EN
      chk("t2_perf_nstall", perf_nstall, 32'd5);
`endif

      // Address wrap-around
      add_req(32'hFFFF_FFF0, 32'd0, mkblk(16'hC000));
      run(22);
      chk("t3_addr_beat0", obs_addr[1], 32'hFFFF_FFF0);
      chk("t3_addr_beat8", obs_addr[9], 32'h0000_0000);
      chk("t3_addr_beat17", obs_addr[18], 32'h0000_0012);
      chk("t3_done19", 32'(obs_done[19]), 32'h1);

      // Reset during beat 7
      rst_at = 8;
      add_req(32'h3000, 32'd1, mkblk(16'hD000));
      run(14);
      rst_at = -1;
      chk("t4_wr7", 32'(obs_wr[7]), 32'h1);
      chk("t4_wr8", 32'(obs_wr[8]), 32'h0);
      chk("t4_ready8", 32'(obs_ready[8]), 32'h1);
      chk("t4_busy8", 32'(obs_busy[8]), 32'h0);
      for (int c = 8; c < 14; c++) begin
         chk("t4_no_done", 32'(obs_done[c]), 32'h0);
         chk("t4_no_write", 32'(obs_wr[c]), 32'h0);
      end
`ifdef BLOCK_WRITER_PERF_EN
      chk("t4_perf_cleared", perf_nblocks, 32'd0);
`endif
      add_req(32'h3000, 32'd1, mkblk(16'hE000));
      run(22);
      chk("t4_restart_addr", obs_addr[1], 32'h3024);
      chk("t4_restart_data", 32'(obs_data[1]), 32'hE000);
      chk("t4_restart_done", 32'(obs_done[19]), 32'h1);

      // Queue full: three requests on consecutive cycles
      add_req(32'h4000, 32'd0, mkblk(16'hF000));
      add_req(32'h4000, 32'd1, mkblk(16'h1000));
      add_req(32'h2000, 32'h1000_0000, mkblk(16'h2000));
      run(62);
      chk("t5_ready1", 32'(obs_ready[1]), 32'h1);
      chk("t5_ready2", 32'(obs_ready[2]), 32'h0);
      chk("t5_ready19", 32'(obs_ready[19]), 32'h0);
      chk("t5_ready20", 32'(obs_ready[20]), 32'h1);
      chk("t5_ready21", 32'(obs_ready[21]), 32'h0);
      chk("t5_doneA", 32'(obs_done[19]), 32'h1);
      chk("t5_idleA", 32'(obs_wr[19]), 32'h0);
      chk("t5_startB", 32'(obs_wr[20]), 32'h1);
      chk("t5_addrB", obs_addr[20], 32'h4024);
      chk("t5_doneB", 32'(obs_done[38]), 32'h1);
      chk("t5_idleB", 32'(obs_wr[38]), 32'h0);
      chk("t5_startC", 32'(obs_wr[39]), 32'h1);
      chk("t5_addrC", obs_addr[39], 32'h4000_2000);
      chk("t5_dataC", 32'(obs_data[39]), 32'h2000);
      chk("t5_doneC", 32'(obs_done[57]), 32'h1);
      chk("t5_busy57", 32'(obs_busy[57]), 32'h1);
      chk("t5_busy58", 32'(obs_busy[58]), 32'h0);
`ifdef BLOCK_WRITER_PERF_EN
      chk("t5_perf_nblocks", perf_nblocks, 32'd4);
`endif

      chk("model_drained", 32'(exp_q.size()), 32'h0);
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/block_writer.md
# block_writer

Writes fixed-size blocks from the ray-tracing datapath (hit records, shaded pixel blocks) to SDRAM through an Avalon-MM master with a 16-bit data bus. It is the write-direction counterpart of the triangle fetch path. A producer hands over one `BLOCKSZ`-bit block plus an element index. The block computes the SDRAM address, queues the request, and serialises it into 16-bit write beats. A small request queue lets the producer issue the next block while the current one drains.

## Interface
Parameters:
- `NDWORDS`, default 9: 32-bit words per block.
- `BLOCKSZ`, localparam = 32*`NDWORDS`: block width in bits.
- `QDEPTH`, default 2: request queue entries; must be at least 1.

Ports:
- `clk`  in  1: single clock. All logic is on its rising edge.
- `reset`  in  1: asynchronous, active-low reset.
- `baseaddr`  in  32: byte address of element 0. Sampled on accept.
- `index`  in  32: element index. Sampled on accept.
- `data`  in  `BLOCKSZ`: block payload. Sampled on accept.
- `write`  in  1: request valid.
- `ready`  out  1: queue can accept a request.
- `done`  out  1: one-cycle pulse when a block's last beat is accepted by the bus.
- `busy`  out  1: high while the queue is non-empty or a block is in flight.
- `avm_m0_read`  out  1: tied to 0.
- `avm_m0_write`  out  1: write strobe.
- `avm_m0_writedata`  out  16: beat data.
- `avm_m0_address`  out  32: beat byte address.
- `avm_m0_readdata`  in  16: unused.
- `avm_m0_readdatavalid`  in  1: unused.
- `avm_m0_byteenable`  out  2: constant 2'b11.
- `avm_m0_waitrequest`  in  1: slave stall.

## Operation
- **Accept.** A request is accepted when `write && ready`. The queue stores {addr, data}, with addr = `baseaddr` + 4*`NDWORDS`*`index`, truncated to 32 bits (modulo 2^32).
- **Ready.** `ready` = queue not full, computed from the registered count. There is no same-cycle pop bypass: a full queue refuses a push even in the cycle it pops.
- **States:**
  - IDLE: queue empty, waiting.
  - BEAT: bursting the head entry.
  - DONE: signalling completion of the head entry.
- **Transitions:**
  - IDLE → BEAT when the queue is non-empty.
  - BEAT → DONE when the last beat is accepted.
  - DONE → BEAT if the queue still holds an entry after the pop, otherwise DONE → IDLE.
- **Beats.** Beat k, for k = 0..2*`NDWORDS`-1, drives:
  - `avm_m0_writedata` = data[16k+15:16k], so the low half goes first;
  - `avm_m0_address` = addr + 2k, with a 32-bit wrap.
- **Stalls.** `avm_m0_write`, address and writedata are held stable while `avm_m0_waitrequest` is high. The beat counter advances only on `avm_m0_write && !avm_m0_waitrequest`.
- **Completion.** In DONE, `done`=1 for exactly one cycle and the head entry is popped.
- **Arithmetic.** The index multiply is computed at accept and truncated to 32 bits. The beat counter is $clog2(2*`NDWORDS`) bits wide.

## Timing
- **Reset values.** While `reset`=0:
  - 0: `avm_m0_write`, `avm_m0_writedata`, `avm_m0_address`, `done`, `busy`;
  - 1: `ready`;
  - 2'b11: `avm_m0_byteenable`;
  - 0: `avm_m0_read`.
- **Reset mid-burst.** The burst is abandoned and the queue is cleared. No further beats are issued, and `done` does not pulse for the aborted block.
- **First beat.** With the queue empty, a request accepted in cycle 0 asserts `avm_m0_write` in cycle 1.
- **Block duration.** With waitrequest low, the beats occupy cycles 1..2*`NDWORDS`. `done` pulses in cycle 2*`NDWORDS`+1.
- **Back-to-back blocks.** There is exactly one bus-idle cycle (DONE) between consecutive blocks.
- **Simultaneous accept and pop.** Accept and pop in the same cycle is legal when the queue is not full, and the count is unchanged.
- **`busy` fall.** `busy` falls in the cycle after the final `done`.

## Configuration
- **Macro:** `BLOCK_WRITER_PERF_EN`.
- **Defined:** adds two outputs, both cleared by `reset` and both wrapping at 2^32.
  - `perf_nblocks`  out  32: number of `done` pulses.
  - `perf_nstall`  out  32: number of cycles with `avm_m0_write && avm_m0_waitrequest`.
- **Undefined:** neither port nor its counters exist. The remaining behaviour is identical in both builds.

## Test plan
- **Single block.** `NDWORDS`=9, `baseaddr`=0x1000, `index`=3, waitrequest low → 18 beats at 0x106C, 0x106E, …, 0x108E; beat 0 = data[15:0]; `done` in cycle 19.
- **Stall.** Waitrequest high for 5 cycles on beat 4 → address and data hold 0x1074 and data[79:64] for 5 cycles; `done` is 5 cycles later; `perf_nstall`=5 when `BLOCK_WRITER_PERF_EN` is defined.
- **Queue full.** `QDEPTH`=2, three requests on consecutive cycles → the third sees `ready`=0 until the first `done`; the blocks complete in order with one idle cycle between them.
- **Wrap-around.** `baseaddr`=0xFFFFFFF0, `index`=0, `NDWORDS`=9 → beat 8 at 0x00000000, beat 17 at 0x00000012.
- **Reset mid-burst.** `reset` low during beat 7 → `avm_m0_write`=0 immediately; no `done`; `ready`=1, `busy`=0; the next request starts from beat 0.
- **Perf count.** Four blocks complete → `perf_nblocks`=4.
